dac_serial_tx: RTL and testbench
================================

// Module: dac_serial_tx
// PURPOSE
//  Output end of the synth audio path: accepts parallel samples via valid/ready, serialises each into a
//  16-bit SPI-style frame for an external DAC (DAC121S101-class: 2'b00, 2-bit PD mode, 12-bit sample).
//  Generates sync_n/sclk/sdata from the system clock via an internal clock-enable divider.
// PARAMETERS
//  DATA_W     12  sample width; frame length FRAME_BITS = DATA_W+4
//  CLK_DIV    4   clk cycles per sclk half-period (tick period); >=2
//  GAP_TICKS  2   ticks sync_n held high between frames; >=1
//  PD_MODE    2'b00  power-down bits placed in frame[DATA_W+1:DATA_W]
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  rst           in   1       synchronous, active-low reset
//  sample_valid  in   1       sample offered
//  sample        in   DATA_W  unsigned sample, MSB first on wire
//  sample_ready  out  1       block can accept; transfer when valid&&ready on posedge clk
//  sync_n        out  1       frame select, low for whole frame
//  sclk          out  1       serial clock, idle high
//  sdata         out  1       serial data, changes after sclk rise; DAC samples on sclk fall
//  busy          out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, sync_n=1, sclk=1, sdata=0, busy=0, sample_ready=1, divider=0,
//   holding reg empty. Mid-frame reset aborts frame at that edge; no partial resume.
//  Frame = {2'b00, PD_MODE, sample}, shifted MSB first.
//  tick: divider counts 0..CLK_DIV-1 while state!=IDLE, tick=1 at CLK_DIV-1; divider cleared in IDLE.
//  FSM: IDLE -> SETUP -> SHIFT -> GAP -> IDLE (or SETUP).
//   IDLE : on valid&&ready load shift reg, next cycle sync_n=0, sdata=frame MSB, state=SETUP.
//   SETUP: sclk=1 for one tick; on tick -> SHIFT, sclk falls (DAC samples bit FRAME_BITS-1).
//   SHIFT: each tick toggles sclk; on each rise shift reg shifts left, sdata = next bit.
//          After FRAME_BITS falls and final rise (2*FRAME_BITS ticks) -> GAP, sync_n=1, sdata=0.
//   GAP  : sync_n=1, sclk=1 for GAP_TICKS ticks, then IDLE (or SETUP, see CONFIGURATION).
//  Latency: accept at edge 0; sync_n falls edge 1; first sclk fall edge 1+CLK_DIV;
//   sync_n rises edge 1+CLK_DIV*(1+2*FRAME_BITS); back-to-back period CLK_DIV*(1+2*FRAME_BITS+GAP_TICKS)+1.
//  sample_ready is a registered-state function only; never combinationally depends on sample_valid.
//  sample sampled only on the accepting edge; later changes ignored.
//  Outputs sync_n, sclk, sdata registered (glitch-free).
// CONFIGURATION
//  DAC_TX_DBUF_EN defined: one-entry holding register. sample_ready = holding empty (any state).
//   Accepted sample while busy goes to holding; at GAP end with holding full -> SETUP directly
//   (no IDLE cycle), holding moved to shift reg, sync_n falls that edge; holding pop and new accept
//   on same edge both honoured. Reset clears holding.
//  Not defined: no holding register; sample_ready = (state==IDLE); samples offered while busy stall.
// STRUCTURE
//  Package dac_tx_pkg: state enum {IDLE,SETUP,SHIFT,GAP}, FRAME_HDR_W=4, tick-counter width function.
//  One sub-module: dac_tick_gen (divider -> 1-cycle tick, sync clear input, sync active-low rst).
//  FSM, shift reg, bit counter, holding reg stay in dac_serial_tx.
// TESTING (DATA_W=12, CLK_DIV=4, GAP_TICKS=2, PD_MODE=0)
//  Reset: hold rst=0 3 cycles -> sync_n=1, sclk=1, sdata=0, busy=0, sample_ready=1.
//  Single frame sample=12'hA5C -> bits sampled on sclk falls = 0000_1010_0101_1100; sync_n low 132 cycles;
//   16 sclk falls; sample_ready low throughout (no DBUF).
//  Back-to-back 12'hFFF,12'h001 with valid held -> second frame starts 141 cycles after first accept
//   (no DBUF); with DAC_TX_DBUF_EN second accepted edge 1, sync_n high exactly 8 cycles between frames.
//  rst=0 at 10th sclk fall -> next edge sync_n=1, sclk=1, busy=0; next sample transmits full correct frame.
//  valid pulsed while busy (no DBUF) -> not accepted, no extra frame; valid high in IDLE with sample
//   changing after accept -> wire carries value at accept edge.
//  Scoreboard: 200 random samples with random valid gaps -> DAC model decodes identical sequence.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// rtl/dac_tx_pkg.sv - shared types, constants and sizing helper for the DAC serial transmitter
package dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    localparam int FRAME_HDR_W = 4;

    // bits needed for a counter running 0..n-1 (never less than one bit)
    function automatic int ctr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// rtl/dac_tick_gen.sv - clock-enable divider producing a one-cycle tick every CLK_DIV clocks
module dac_tick_gen
    import dac_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = ctr_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // divider: held at zero while cleared, otherwise wraps at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - sample-to-SPI DAC frame serialiser; define DAC_TX_DBUF_EN for a one-entry holding register
module dac_serial_tx
    import dac_tx_pkg::*;
#(
    parameter int         DATA_W    = 12,
    parameter int         CLK_DIV   = 4,
    parameter int         GAP_TICKS = 2,
    parameter logic [1:0] PD_MODE   = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              sample_ready,
    output logic              sync_n,
    output logic              sclk,
    output logic              sdata,
    output logic              busy
);

    localparam int FRAME_BITS  = DATA_W + FRAME_HDR_W;
    localparam int SHIFT_TICKS = 2 * FRAME_BITS;
    localparam int TCNT_N      = (SHIFT_TICKS > GAP_TICKS) ? SHIFT_TICKS : GAP_TICKS;
    localparam int TCNT_W      = ctr_w(TCNT_N);
    localparam logic [TCNT_W-1:0] SHIFT_LAST = TCNT_W'(SHIFT_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(GAP_TICKS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [TCNT_W-1:0]     tcnt;
    logic                  phase;
    logic                  tick;
    logic                  accept;
    logic                  idle_start;
    logic                  gap_restart;
    logic                  load;
    logic [DATA_W-1:0]     load_data;
    logic                  sync_n_d;
    logic                  sclk_d;
    logic                  sdata_d;

    dac_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    assign accept = sample_valid && sample_ready;
    assign busy   = (state != IDLE);
    // a frame is (re)loaded whenever SETUP is entered from outside
    assign load   = (state_next == SETUP) && (state != SETUP);

`ifdef DAC_TX_DBUF_EN
    logic              hold_valid;
    logic [DATA_W-1:0] hold_data;

    assign sample_ready = !hold_valid;
    assign idle_start   = hold_valid || accept;
    assign gap_restart  = hold_valid;
    assign load_data    = hold_valid ? hold_data : sample;

    // holding register: fills on accepts while a frame is in flight, drains into the shifter on load
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (accept && state != IDLE) begin
            hold_valid <= 1'b1;
            hold_data  <= sample;
        end else if (load && hold_valid) begin
            hold_valid <= 1'b0;
        end
    end
`else
    assign sample_ready = (state == IDLE);
    assign idle_start   = accept;
    assign gap_restart  = 1'b0;
    assign load_data    = sample;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic, advanced only on divider ticks once a frame is running
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (idle_start) state_next = SETUP;
            SETUP: if (tick) state_next = SHIFT;
            SHIFT: if (tick && tcnt == SHIFT_LAST) state_next = GAP;
            GAP:   if (tick && tcnt == GAP_LAST) state_next = gap_restart ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // shifter, tick counter and sclk phase; the shifter advances on each sclk rise
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg <= '0;
            tcnt      <= '0;
            phase     <= 1'b1;
        end else if (load) begin
            shift_reg <= {2'b00, PD_MODE, load_data};
            tcnt      <= '0;
            phase     <= 1'b1;
        end else begin
            case (state)
                SETUP: begin
                    if (tick) begin
                        phase <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (tcnt == SHIFT_LAST) begin
                            tcnt  <= '0;
                            phase <= 1'b1;
                        end else begin
                            tcnt  <= tcnt + TCNT_W'(1);
                            phase <= ~phase;
                            if (!phase) begin
                                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        tcnt <= (tcnt == GAP_LAST) ? '0 : tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    tcnt <= '0;
                end
            endcase
        end
    end

    // wire-level values implied by the current state; registered below
    always_comb begin
        sync_n_d = 1'b1;
        sclk_d   = 1'b1;
        sdata_d  = 1'b0;
        case (state)
            SETUP: begin
                sync_n_d = 1'b0;
                sdata_d  = shift_reg[FRAME_BITS-1];
            end
            SHIFT: begin
                sync_n_d = 1'b0;
                sclk_d   = phase;
                sdata_d  = shift_reg[FRAME_BITS-1];
            end
            default: begin
                sync_n_d = 1'b1;
            end
        endcase
    end

    // registered pins keep sync_n/sclk/sdata glitch-free
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_n <= 1'b1;
            sclk   <= 1'b1;
            sdata  <= 1'b0;
        end else begin
            sync_n <= sync_n_d;
            sclk   <= sclk_d;
            sdata  <= sdata_d;
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - directed-vector and scoreboard bench for dac_serial_tx
module tb_dac_serial_tx;

`ifdef DAC_TX_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic        sample_ready;
    logic        sync_n;
    logic        sclk;
    logic        sdata;
    logic        busy;

    always #5 clk = ~clk;

    dac_serial_tx #(
        .DATA_W    (12),
        .CLK_DIV   (4),
        .GAP_TICKS (2),
        .PD_MODE   (2'b00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (sample_ready),
        .sync_n       (sync_n),
        .sclk         (sclk),
        .sdata        (sdata),
        .busy         (busy)
    );

    typedef struct {
        logic [11:0] smp;
        logic [15:0] frame;
    } vec_t;

    typedef struct {
        logic [15:0] frame;
        int          low;
        int          falls;
        bit          rdy_hi;
        int          fall_c;
        int          ff_c;
        int          rise_c;
    } rec_t;

    rec_t recs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // DAC model: shifts sdata on every sclk fall inside a sync_n low window
    logic        prev_sclk = 1'b1;
    logic        prev_sync = 1'b1;
    logic [15:0] m_frame = '0;
    int          m_falls = 0;
    int          m_low = 0;
    int          m_fall_c = 0;
    int          m_ff_c = 0;
    bit          m_rdy = 1'b0;

    always @(negedge clk) begin
        prev_sclk <= sclk;
        prev_sync <= sync_n;
        if (prev_sync === 1'b1 && sync_n === 1'b0) begin
            m_frame  <= '0;
            m_falls  <= 0;
            m_low    <= 1;
            m_fall_c <= cyc;
            m_ff_c   <= -1;
            m_rdy    <= (sample_ready === 1'b1);
        end else if (sync_n === 1'b0) begin
            m_low <= m_low + 1;
            if (sample_ready === 1'b1) m_rdy <= 1'b1;
            if (prev_sclk === 1'b1 && sclk === 1'b0) begin
                m_frame <= {m_frame[14:0], sdata};
                m_falls <= m_falls + 1;
                if (m_falls == 0) m_ff_c <= cyc;
            end
        end else if (prev_sync === 1'b0 && sync_n === 1'b1) begin
            recs.push_back('{m_frame, m_low, m_falls, m_rdy, m_fall_c, m_ff_c, cyc});
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [11:0] s, input bit keep, input logic [11:0] nxt,
                         output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            sample       = s;
            sample_valid = 1'b1;
            if (sample_ready === 1'b1) begin
                acc = cyc + 1;
                @(posedge clk);
                #1;
                if (keep) begin
                    sample = nxt;
                end else begin
                    sample_valid = 1'b0;
                    sample       = ~s;
                end
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            sample_valid = 1'b0;
            check("offer_timeout", 0, 1);
        end
    endtask

    task automatic wait_recs(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (recs.size() >= n) return;
        end
        check("frame_wait_count", recs.size(), n);
    endtask

    vec_t        vecs[6];
    logic [11:0] exp_q[$];
    rec_t        r;
    int          acc, acc2;
    bit          ok, reached;
    logic [11:0] rs;

    initial begin
        vecs[0] = '{12'hA5C, 16'h0A5C};
        vecs[1] = '{12'hFFF, 16'h0FFF};
        vecs[2] = '{12'h000, 16'h0000};
        vecs[3] = '{12'h001, 16'h0001};
        vecs[4] = '{12'h800, 16'h0800};
        vecs[5] = '{12'h555, 16'h0555};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_sync_n", sync_n, 1);
        check("reset_sclk", sclk, 1);
        check("reset_sdata", sdata, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", sample_ready, 1);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            recs.delete();
            offer(vecs[v].smp, 1'b0, 12'h0, acc, ok);
            wait_recs(1, 400);
            if (ok && recs.size() > 0) begin
                r = recs[0];
                check("vec_frame", r.frame, vecs[v].frame);
                check("vec_sync_low_cycles", r.low, 132);
                check("vec_sclk_falls", r.falls, 16);
                check("vec_ready_during_frame", r.rdy_hi, DBUF);
                check("vec_sync_fall_latency", r.fall_c - acc, 1);
                check("vec_first_fall_latency", r.ff_c - acc, 5);
                check("vec_sync_rise_latency", r.rise_c - acc, 133);
            end
        end

        recs.delete();
        offer(12'hFFF, 1'b1, 12'h001, acc, ok);
        offer(12'h001, 1'b0, 12'h0, acc2, ok);
        check("b2b_accept_spacing", acc2 - acc, DBUF ? 1 : 141);
        wait_recs(2, 800);
        if (recs.size() >= 2) begin
            check("b2b_frame0", recs[0].frame, 16'h0FFF);
            check("b2b_frame1", recs[1].frame, 16'h0001);
            check("b2b_sync_high_gap", recs[1].fall_c - recs[0].rise_c, DBUF ? 8 : 9);
        end

`ifndef DAC_TX_DBUF_EN
        recs.delete();
        offer(12'h5A5, 1'b0, 12'h0, acc, ok);
        repeat (20) @(negedge clk);
        sample       = 12'h777;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_recs(1, 400);
        repeat (200) @(negedge clk);
        check("busy_pulse_frame_count", recs.size(), 1);
        if (recs.size() > 0) check("busy_pulse_frame", recs[0].frame, 16'h05A5);
        check("busy_pulse_idle", busy, 0);
`endif

        recs.delete();
        offer(12'h6B3, 1'b0, 12'h0, acc, ok);
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (m_falls == 10 && sync_n === 1'b0) begin
                reached = 1'b1;
                break;
            end
        end
        check("midreset_reached_fall10", reached, 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_sync_n", sync_n, 1);
        check("midreset_sclk", sclk, 1);
        check("midreset_busy", busy, 0);
        check("midreset_sdata", sdata, 0);
        rst = 1'b1;
        recs.delete();
        offer(12'h3C7, 1'b0, 12'h0, acc, ok);
        wait_recs(1, 400);
        if (recs.size() > 0) begin
            check("postreset_frame", recs[0].frame, 16'h03C7);
            check("postreset_falls", recs[0].falls, 16);
        end

        recs.delete();
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            rs = 12'($urandom_range(0, 4095));
            offer(rs, 1'b0, 12'h0, acc, ok);
            if (ok) exp_q.push_back(rs);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_recs(exp_q.size(), 3000);
        check("rand_frame_count", recs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < recs.size(); k++) begin
            check("rand_frame", recs[k].frame, {4'h0, exp_q[k]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
